apb_slot_ctrl: RTL and testbench

- Sequences the MSS fabric APB3 master port (MSSPSEL/MSSPENABLE/MSSPWRITE/MSSPADDR/MSSPWDATA, returning MSSPRDATA/MSSPREADY/MSSPSLVERR) onto up to NUM_SLOTS fabric peripherals, e.g. the GameCube controller interface and the speaker DAC engine.
- Decodes a slot field from the address and re-issues the transfer as a registered APB3 transfer on the selected slot.
- Bounds every access with a wait-state timeout and counts and records errors.
- Sits between gc_MSS and the fabric peripherals, clocked from FAB_CLK.

---
 rtl/apb_slot_ctrl.sv | 116 +++++++++++
 tb/tb_apb_slot_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/apb_slot_ctrl.sv
// apb_slot_ctrl: bridges the MSS APB3 master onto NUM_SLOTS fabric slaves with timeout and error logging
module apb_slot_ctrl #(
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_LSB = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                    SYSCLK,
  input  logic                    SYSRESET,
  input  logic                    MSSPSEL,
  input  logic                    MSSPENABLE,
  input  logic                    MSSPWRITE,
  input  logic [31:0]             MSSPADDR,
  input  logic [31:0]             MSSPWDATA,
  output logic [31:0]             MSSPRDATA,
  output logic                    MSSPREADY,
  output logic                    MSSPSLVERR,
  output logic [NUM_SLOTS-1:0]    S_PSEL,
  output logic                    S_PENABLE,
  output logic                    S_PWRITE,
  output logic [7:0]              S_PADDR,
  output logic [31:0]             S_PWDATA,
  input  logic [32*NUM_SLOTS-1:0] S_PRDATA,
  input  logic [NUM_SLOTS-1:0]    S_PREADY,
  input  logic [NUM_SLOTS-1:0]    S_PSLVERR,
  output logic [7:0]              ERR_COUNT,
  output logic [31:0]             LAST_ERR_ADDR
);
  typedef enum logic [1:0] {IDLE, SLV_SETUP, SLV_ACCESS, RESPOND} state_t;
  localparam logic [4:0] NS = 5'(NUM_SLOTS);
  state_t state, state_d;
  logic [31:0] addr_q, wdata_q, rdata_q, rdata_d, sel_rdata, addr_d;
  logic [3:0] slot_q, slot_in;
  logic [7:0] cnt;
  logic write_q, err_q, err_d, sel_ready, sel_err, load, active, log_err;
  assign slot_in = MSSPADDR[SLOT_LSB+3:SLOT_LSB];
  assign addr_d = load ? MSSPADDR : addr_q;
  assign active = state == SLV_SETUP || state == SLV_ACCESS;
  assign log_err = state != RESPOND && state_d == RESPOND && err_d;
  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    sel_err = 1'b0;
    for (int k = 0; k < NUM_SLOTS; k++)
      if (slot_q == 4'(k)) begin
        sel_rdata = S_PRDATA[32*k +: 32];
        sel_ready = S_PREADY[k];
        sel_err = S_PSLVERR[k];
      end
  end
  // a dropped MSSPSEL mid-transfer abandons it silently
  always_comb begin
    state_d = state;
    err_d = err_q;
    rdata_d = rdata_q;
    load = 1'b0;
    case (state)
      IDLE: if (MSSPSEL && !MSSPENABLE) begin
        load = 1'b1;
        if ({1'b0, slot_in} < NS) state_d = SLV_SETUP;
        else begin
          state_d = RESPOND;
          err_d = 1'b1;
          rdata_d = '0;
        end
      end
      SLV_SETUP: state_d = MSSPSEL ? SLV_ACCESS : IDLE;
      SLV_ACCESS: if (!MSSPSEL) state_d = IDLE;
      else if (sel_ready) begin
        state_d = RESPOND;
        err_d = sel_err;
        rdata_d = sel_rdata;
      end else if (cnt == 8'(TIMEOUT - 1)) begin
        state_d = RESPOND;
        err_d = 1'b1;
        rdata_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge SYSCLK or posedge SYSRESET)
    if (SYSRESET) begin
      state <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      slot_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
      cnt <= '0;
      ERR_COUNT <= '0;
      LAST_ERR_ADDR <= '0;
    end else begin
      state <= state_d;
      err_q <= err_d;
      rdata_q <= rdata_d;
      addr_q <= addr_d;
      if (load) begin
        wdata_q <= MSSPWDATA;
        write_q <= MSSPWRITE;
        slot_q <= slot_in;
      end
      cnt <= state == SLV_SETUP ? '0 : state == SLV_ACCESS && state_d == SLV_ACCESS ? cnt + 8'd1 : cnt;
      if (log_err) begin
        ERR_COUNT <= ERR_COUNT == 8'hFF ? ERR_COUNT : ERR_COUNT + 8'd1;
        LAST_ERR_ADDR <= addr_d;
      end
    end
  assign S_PSEL = active ? NUM_SLOTS'(1) << slot_q : '0;
  assign S_PENABLE = state == SLV_ACCESS;
  assign S_PWRITE = active && write_q;
  assign S_PADDR = active ? addr_q[7:0] : '0;
  assign S_PWDATA = active ? wdata_q : '0;
  assign MSSPREADY = state == RESPOND;
  assign MSSPSLVERR = state == RESPOND && err_q;
  assign MSSPRDATA = state == RESPOND && !write_q ? rdata_q : '0;
endmodule

// File: tb/tb_apb_slot_ctrl.sv
// tb_apb_slot_ctrl: directed self-checking bench for apb_slot_ctrl (NUM_SLOTS=4, TIMEOUT=8)
module tb_apb_slot_ctrl;
  logic clk = 0, rst = 1;
  logic psel = 0, pen = 0, pwr = 0;
  logic [31:0] paddr = 0, pwdata = 0, prdata;
  logic pready, pslverr;
  logic [3:0] s_psel, s_pready, slv_err = 0;
  logic s_pen, s_pwr;
  logic [7:0] s_paddr, err_count;
  logic [31:0] s_pwdata, last_err;
  logic [127:0] s_prdata;
  int errors = 0, checks = 0, wait_n = 0, acc = 0;
  logic [31:0] got_rdata, seen_paddr, seen_pwdata;
  logic got_err, seen_pwr;
  logic [3:0] psel_or;
  int lat, pen_cnt;

  always #5 clk = ~clk;
  assign s_prdata = {32'h33333333, 32'hCAFEF00D, 32'hB1B1B1B1, 32'hA0A0A0A0};
  always @(posedge clk) acc <= s_pen ? acc + 1 : 0;
  assign s_pready = (s_pen && acc >= wait_n) ? 4'hF : 4'h0;

  apb_slot_ctrl #(.NUM_SLOTS(4), .SLOT_LSB(8), .TIMEOUT(8)) dut (
    .SYSCLK(clk), .SYSRESET(rst), .MSSPSEL(psel), .MSSPENABLE(pen), .MSSPWRITE(pwr),
    .MSSPADDR(paddr), .MSSPWDATA(pwdata), .MSSPRDATA(prdata), .MSSPREADY(pready),
    .MSSPSLVERR(pslverr), .S_PSEL(s_psel), .S_PENABLE(s_pen), .S_PWRITE(s_pwr),
    .S_PADDR(s_paddr), .S_PWDATA(s_pwdata), .S_PRDATA(s_prdata), .S_PREADY(s_pready),
    .S_PSLVERR(slv_err), .ERR_COUNT(err_count), .LAST_ERR_ADDR(last_err));

  // lat counts cycles from SETUP (T0) to the cycle MSSPREADY is seen
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d);
    logic done = 0;
    @(posedge clk); #1;
    psel = 1; pen = 0; pwr = w; paddr = a; pwdata = d;
    psel_or = 0; pen_cnt = 0; lat = 0; got_rdata = 0; got_err = 0;
    seen_paddr = 0; seen_pwdata = 0; seen_pwr = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      psel_or = psel_or | s_psel;
      if (s_pen) begin
        pen_cnt++;
        seen_paddr = {24'd0, s_paddr}; seen_pwdata = s_pwdata; seen_pwr = s_pwr;
      end
      if (pready) begin
        got_rdata = prdata; got_err = pslverr; done = 1;
        break;
      end
      @(posedge clk); #1;
      pen = 1; lat++;
    end
    checks++;
    if (!done) begin errors++; $display("FAIL xfer_timeout addr=%h no MSSPREADY within 40 cycles", a); end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    psel = 0; pen = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({pready, pslverr, prdata, s_psel, s_pen, s_pwr, s_paddr, s_pwdata, err_count, last_err} !== '0) begin
      errors++; $display("FAIL reset_outputs got psel=%b pen=%b rdy=%b errc=%h exp all zero", s_psel, s_pen, pready, err_count);
    end
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    checks++;
    if ({pready, s_psel, s_pen, err_count} !== '0) begin errors++; $display("FAIL post_reset_idle got rdy=%b psel=%b", pready, s_psel); end
  endtask

  task automatic test_write();
    wait_n = 0;
    xfer(1, 32'h40050104, 32'h12345678);
    checks++; if (psel_or !== 4'b0010) begin errors++; $display("FAIL wr_psel got %b exp 0010", psel_or); end
    checks++; if (seen_paddr !== 32'h04) begin errors++; $display("FAIL wr_paddr got %h exp 04", seen_paddr); end
    checks++; if (seen_pwdata !== 32'h12345678) begin errors++; $display("FAIL wr_pwdata got %h exp 12345678", seen_pwdata); end
    checks++; if (seen_pwr !== 1'b1) begin errors++; $display("FAIL wr_pwrite got %b exp 1", seen_pwr); end
    checks++; if (pen_cnt !== 1) begin errors++; $display("FAIL wr_access_cycles got %0d exp 1", pen_cnt); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL wr_latency got T%0d exp T3", lat); end
    checks++; if (got_err !== 1'b0 || got_rdata !== 32'h0) begin errors++; $display("FAIL wr_resp got err=%b rdata=%h exp 0/0", got_err, got_rdata); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL wr_errcount got %0d exp 0", err_count); end
  endtask

  task automatic test_read_wait();
    wait_n = 3;
    xfer(0, 32'h40050200, 32'h0);
    checks++; if (got_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL rd_data got %h exp cafef00d", got_rdata); end
    checks++; if (lat !== 6) begin errors++; $display("FAIL rd_latency got T%0d exp T6", lat); end
    checks++; if (psel_or !== 4'b0100) begin errors++; $display("FAIL rd_psel got %b exp 0100", psel_or); end
    checks++; if (pen_cnt !== 4 || seen_pwr !== 1'b0) begin errors++; $display("FAIL rd_access got %0d pwrite=%b exp 4/0", pen_cnt, seen_pwr); end
    wait_n = 0;
  endtask

  task automatic test_decode_err();
    xfer(0, 32'h40050700, 32'h0);
    checks++; if (lat !== 1 || got_err !== 1'b1) begin errors++; $display("FAIL dec_resp got T%0d err=%b exp T1 err=1", lat, got_err); end
    checks++; if (got_rdata !== 32'h0 || psel_or !== 4'b0) begin errors++; $display("FAIL dec_quiet got rdata=%h psel=%b exp 0/0", got_rdata, psel_or); end
    @(negedge clk);
    checks++; if (err_count !== 8'd1 || last_err !== 32'h40050700) begin errors++; $display("FAIL dec_log got cnt=%0d addr=%h exp 1/40050700", err_count, last_err); end
  endtask

  task automatic test_timeout();
    wait_n = 100;
    xfer(0, 32'h40050010, 32'h0);
    checks++; if (pen_cnt !== 8) begin errors++; $display("FAIL to_penable_cycles got %0d exp 8", pen_cnt); end
    checks++; if (lat !== 10 || got_err !== 1'b1 || got_rdata !== 32'h0) begin errors++; $display("FAIL to_resp got T%0d err=%b rdata=%h exp T10/1/0", lat, got_err, got_rdata); end
    @(negedge clk);
    checks++; if (err_count !== 8'd2 || last_err !== 32'h40050010) begin errors++; $display("FAIL to_log got cnt=%0d addr=%h exp 2/40050010", err_count, last_err); end
    wait_n = 7;
    xfer(0, 32'h40050014, 32'h0);
    checks++; if (got_err !== 1'b0 || got_rdata !== 32'hA0A0A0A0 || lat !== 10) begin errors++; $display("FAIL last_cycle_ready got err=%b rdata=%h T%0d exp 0/a0a0a0a0/T10", got_err, got_rdata, lat); end
    @(negedge clk);
    checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL last_cycle_errcount got %0d exp 2", err_count); end
    wait_n = 0;
  endtask

  task automatic test_slave_err();
    slv_err = 4'b1000;
    xfer(0, 32'h40050308, 32'h0);
    checks++; if (got_err !== 1'b1 || got_rdata !== 32'h33333333) begin errors++; $display("FAIL slverr_resp got err=%b rdata=%h exp 1/33333333", got_err, got_rdata); end
    slv_err = 0;
    @(negedge clk);
    checks++; if (err_count !== 8'd3 || last_err !== 32'h40050308) begin errors++; $display("FAIL slverr_log got cnt=%0d addr=%h exp 3/40050308", err_count, last_err); end
  endtask

  task automatic test_abort();
    logic seen_rdy = 0;
    wait_n = 100;
    idle();
    @(posedge clk); #1 psel = 1; pen = 0; pwr = 0; paddr = 32'h40050120;
    @(posedge clk); #1 pen = 1;
    @(posedge clk); #1 psel = 0; pen = 0;
    @(negedge clk);
    checks++; if (s_pen !== 1'b1 || s_psel !== 4'b0010) begin errors++; $display("FAIL abort_in_access got pen=%b psel=%b exp 1/0010", s_pen, s_psel); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen_rdy = seen_rdy | pready | s_pen | (|s_psel);
    end
    checks++; if (seen_rdy !== 1'b0 || err_count !== 8'd3) begin errors++; $display("FAIL abort_quiet got activity=%b cnt=%0d exp 0/3", seen_rdy, err_count); end
    wait_n = 0;
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++) xfer(0, 32'h40050C00 + i, 32'h0);
    idle();
    @(negedge clk);
    checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_errcount got %0d exp 255", err_count); end
    checks++; if (last_err !== 32'h40050C00 + 299) begin errors++; $display("FAIL sat_lastaddr got %h exp %h", last_err, 32'h40050C00 + 299); end
  endtask

  task automatic test_async_reset();
    wait_n = 100;
    @(posedge clk); #1 psel = 1; pen = 0; pwr = 0; paddr = 32'h40050000;
    @(posedge clk); #1 pen = 1;
    @(posedge clk); #3;
    checks++; if (s_pen !== 1'b1) begin errors++; $display("FAIL ar_pre got pen=%b exp 1", s_pen); end
    rst = 1; #1;
    checks++; if ({s_psel, s_pen, pready, err_count, last_err} !== '0) begin errors++; $display("FAIL ar_clear got psel=%b pen=%b rdy=%b cnt=%0d exp all 0", s_psel, s_pen, pready, err_count); end
    psel = 0; pen = 0; wait_n = 0;
    @(posedge clk); #1 rst = 0;
    xfer(0, 32'h40050100, 32'h0);
    checks++; if (lat !== 3 || got_err !== 1'b0 || got_rdata !== 32'hB1B1B1B1) begin errors++; $display("FAIL ar_next got T%0d err=%b rdata=%h exp T3/0/b1b1b1b1", lat, got_err, got_rdata); end
  endtask

  task automatic test_back_to_back();
    xfer(1, 32'h40050000, 32'hDEADBEEF);
    xfer(0, 32'h40050300, 32'h0);
    checks++; if (lat !== 3 || got_rdata !== 32'h33333333 || got_err !== 1'b0) begin errors++; $display("FAIL b2b_second got T%0d rdata=%h err=%b exp T3/33333333/0", lat, got_rdata, got_err); end
    idle();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_decode_err();
    test_timeout();
    test_slave_err();
    test_abort();
    test_saturate();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
